// File: rtl/axi4lite_master_arbiter.sv
// Round-robin arbiter that funnels NREQ single-beat read/write requesters onto one
// AXI4-Lite master port, with exactly one AXI transaction in flight at a time.
module axi4lite_master_arbiter #(
   parameter int         NREQ   = 2,
   parameter int         AWIDTH = 12,
   parameter int         DWIDTH = 32,
   parameter int         SWIDTH = DWIDTH/8,
   parameter logic [2:0] PROT   = 3'b000
) (
   input  logic                     i_aClk,
   input  logic                     i_aReset,
   input  logic [NREQ-1:0]          i_reqValid,
   output logic [NREQ-1:0]          o_reqReady,
   input  logic [NREQ-1:0]          i_reqWrite,
   input  logic [NREQ*AWIDTH-1:0]   i_reqAddr,
   input  logic [NREQ*DWIDTH-1:0]   i_reqData,
   input  logic [NREQ*SWIDTH-1:0]   i_reqStrb,
   output logic [NREQ-1:0]          o_rspValid,
   output logic [DWIDTH-1:0]        o_rspData,
   output logic [1:0]               o_rspResp,
   output logic                     o_arValid,
   input  logic                     i_arReady,
   output logic [AWIDTH-1:0]        o_arAddr,
   output logic [2:0]               o_arProt,
   input  logic                     i_rValid,
   output logic                     o_rReady,
   input  logic [DWIDTH-1:0]        i_rData,
   input  logic [1:0]               i_rResp,
   output logic                     o_awValid,
   input  logic                     i_awReady,
   output logic [AWIDTH-1:0]        o_awAddr,
   output logic [2:0]               o_awProt,
   output logic                     o_wValid,
   input  logic                     i_wReady,
   output logic [DWIDTH-1:0]        o_wData,
   output logic [SWIDTH-1:0]        o_wStrb,
   input  logic                     i_bValid,
   output logic                     o_bReady,
   input  logic [1:0]               i_bResp
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR_AW, S_WR_B} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       gnt_q, gnt_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic [DWIDTH-1:0]   data_q, data_d;
   logic [SWIDTH-1:0]   strb_q, strb_d;
   logic                ar_valid_q, ar_valid_d;
   logic                r_ready_q, r_ready_d;
   logic                aw_valid_q, aw_valid_d;
   logic                w_valid_q, w_valid_d;
   logic                b_ready_q, b_ready_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [1:0]          rsp_resp_q, rsp_resp_d;

   logic [AWIDTH-1:0]   req_addr [NREQ];
   logic [DWIDTH-1:0]   req_data [NREQ];
   logic [SWIDTH-1:0]   req_strb [NREQ];
   logic [IW-1:0]       win_idx;
   logic                win_found;
   logic                accept;
   int                  scan_k;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_addr[gi]   = i_reqAddr[gi*AWIDTH +: AWIDTH];
         assign req_data[gi]   = i_reqData[gi*DWIDTH +: DWIDTH];
         assign req_strb[gi]   = i_reqStrb[gi*SWIDTH +: SWIDTH];
         assign o_reqReady[gi] = accept && (win_idx == IW'(gi));
      end
   endgenerate

   // First valid requester at or above the pointer, wrapping past NREQ-1.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      scan_k    = 0;
      for (int i = 0; i < NREQ; i++) begin
         scan_k = int'(ptr_q) + i;
         if (scan_k >= NREQ) scan_k = scan_k - NREQ;
         if (!win_found && i_reqValid[scan_k]) begin
            win_found = 1'b1;
            win_idx   = IW'(scan_k);
         end
      end
   end

   // Gated by reset so no grant is visible while the design is held in reset.
   assign accept = (state_q == S_IDLE) && win_found && !i_aReset;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      strb_d      = strb_q;
      ar_valid_d  = ar_valid_q;
      r_ready_d   = r_ready_q;
      aw_valid_d  = aw_valid_q;
      w_valid_d   = w_valid_q;
      b_ready_d   = b_ready_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_resp_d  = rsp_resp_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               gnt_d  = win_idx;
               ptr_d  = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
               addr_d = req_addr[win_idx];
               data_d = req_data[win_idx];
               strb_d = req_strb[win_idx];
               if (i_reqWrite[win_idx]) begin
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
                  state_d    = S_WR_AW;
               end else begin
                  ar_valid_d = 1'b1;
                  state_d    = S_RD_A;
               end
            end
         end
         S_RD_A: begin
            if (i_arReady) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = S_RD_D;
            end
         end
         S_RD_D: begin
            if (i_rValid) begin
               r_ready_d          = 1'b0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_data_d         = i_rData;
               rsp_resp_d         = i_rResp;
               state_d            = S_IDLE;
            end
         end
         S_WR_AW: begin
            // AW and W complete independently; B is only awaited once both are gone.
            if (aw_valid_q && i_awReady) aw_valid_d = 1'b0;
            if (w_valid_q && i_wReady)   w_valid_d  = 1'b0;
            if (!aw_valid_d && !w_valid_d) begin
               b_ready_d = 1'b1;
               state_d   = S_WR_B;
            end
         end
         S_WR_B: begin
            if (i_bValid) begin
               b_ready_d          = 1'b0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_data_d         = '0;
               rsp_resp_d         = i_bResp;
               state_d            = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_aClk or posedge i_aReset) begin
      if (i_aReset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_resp_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         strb_q      <= strb_d;
         ar_valid_q  <= ar_valid_d;
         r_ready_q   <= r_ready_d;
         aw_valid_q  <= aw_valid_d;
         w_valid_q   <= w_valid_d;
         b_ready_q   <= b_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   assign o_arValid  = ar_valid_q;
   assign o_arAddr   = addr_q;
   assign o_arProt   = PROT;
   assign o_rReady   = r_ready_q;
   assign o_awValid  = aw_valid_q;
   assign o_awAddr   = addr_q;
   assign o_awProt   = PROT;
   assign o_wValid   = w_valid_q;
   assign o_wData    = data_q;
   assign o_wStrb    = strb_q;
   assign o_bReady   = b_ready_q;
   assign o_rspValid = rsp_valid_q;
   assign o_rspData  = rsp_data_q;
   assign o_rspResp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Randomized requesters and AXI slave around the arbiter, scored against a
// transaction-level model of round-robin grant order and channel sequencing.
module tb_axi4lite_master_arbiter;
   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = DW/8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      i_reqValid, o_reqReady, i_reqWrite, o_rspValid;
   logic [N*AW-1:0]   i_reqAddr;
   logic [N*DW-1:0]   i_reqData;
   logic [N*SW-1:0]   i_reqStrb;
   logic [DW-1:0]     o_rspData;
   logic [1:0]        o_rspResp;
   logic              o_arValid, i_arReady, i_rValid, o_rReady;
   logic [AW-1:0]     o_arAddr, o_awAddr;
   logic [2:0]        o_arProt, o_awProt;
   logic [DW-1:0]     i_rData, o_wData;
   logic [1:0]        i_rResp, i_bResp;
   logic              o_awValid, i_awReady, o_wValid, i_wReady, i_bValid, o_bReady;
   logic [SW-1:0]     o_wStrb;

   axi4lite_master_arbiter #(.NREQ(N), .AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW), .PROT(3'b000)) dut (
      .i_aClk(clk), .i_aReset(rst),
      .i_reqValid(i_reqValid), .o_reqReady(o_reqReady), .i_reqWrite(i_reqWrite),
      .i_reqAddr(i_reqAddr), .i_reqData(i_reqData), .i_reqStrb(i_reqStrb),
      .o_rspValid(o_rspValid), .o_rspData(o_rspData), .o_rspResp(o_rspResp),
      .o_arValid(o_arValid), .i_arReady(i_arReady), .o_arAddr(o_arAddr), .o_arProt(o_arProt),
      .i_rValid(i_rValid), .o_rReady(o_rReady), .i_rData(i_rData), .i_rResp(i_rResp),
      .o_awValid(o_awValid), .i_awReady(i_awReady), .o_awAddr(o_awAddr), .o_awProt(o_awProt),
      .o_wValid(o_wValid), .i_wReady(i_wReady), .o_wData(o_wData), .o_wStrb(o_wStrb),
      .i_bValid(i_bValid), .o_bReady(o_bReady), .i_bResp(i_bResp)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   function automatic bit chance(input int pct);
      return $urandom_range(99) < pct;
   endfunction

   function automatic logic any_output();
      return |{o_reqReady, o_rspValid, o_arValid, o_rReady, o_awValid, o_wValid, o_bReady,
               o_arAddr, o_awAddr, o_wData, o_wStrb, o_rspData, o_rspResp};
   endfunction

   // requester-side commands, held until granted
   bit            hold [N];
   bit            rq_w [N];
   logic [AW-1:0] rq_a [N];
   logic [DW-1:0] rq_d [N];
   logic [SW-1:0] rq_s [N];

   // transaction-level model of the arbiter
   int            mptr;
   bit            busy, wr, ar_done, r_done, aw_done, w_done, b_done, rsp_pend;
   int            g, ntxn;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data, rsp_d;
   logic [SW-1:0] e_strb;
   logic [1:0]    rsp_r;
   bit            force_all, post_chk, mid_rst_done;

   int req_pct [4] = '{100, 60, 100, 40};
   int rdy_pct [4] = '{100, 40, 15, 70};
   int ncyc    [4] = '{120, 400, 300, 300};

   task automatic model_reset();
      mptr = 0; busy = 0; rsp_pend = 0;
      ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
      for (int k = 0; k < N; k++) hold[k] = 0;
   endtask

   task automatic drive_idle_inputs();
      i_reqValid = '0; i_reqWrite = '0; i_reqAddr = '0; i_reqData = '0; i_reqStrb = '0;
      i_arReady = 0; i_rValid = 0; i_rData = '0; i_rResp = '0;
      i_awReady = 0; i_wReady = 0; i_bValid = 0; i_bResp = '0;
   endtask

   task automatic drive_cycle(input int rp, input int sp);
      for (int k = 0; k < N; k++) begin
         if (!hold[k] && (force_all || chance(rp))) begin
            hold[k] = 1;
            rq_w[k] = 1'($urandom_range(1));
            rq_a[k] = AW'($urandom);
            rq_d[k] = DW'($urandom);
            rq_s[k] = SW'($urandom);
         end
         i_reqValid[k]           = hold[k];
         i_reqWrite[k]           = rq_w[k];
         i_reqAddr[k*AW +: AW]   = rq_a[k];
         i_reqData[k*DW +: DW]   = rq_d[k];
         i_reqStrb[k*SW +: SW]   = rq_s[k];
      end
      force_all = 0;
      i_arReady = chance(sp);
      i_awReady = chance(sp);
      i_wReady  = chance(sp);
      i_rValid  = busy && !wr && ar_done && !r_done && chance(sp);
      i_rData   = DW'($urandom);
      i_rResp   = 2'($urandom_range(3));
      i_bValid  = busy && wr && aw_done && w_done && !b_done && chance(sp);
      i_bResp   = 2'($urandom_range(3));
   endtask

   task automatic sample_cycle();
      bit e_ar, e_r, e_aw, e_w, e_b;
      logic [N-1:0] exp_rdy;
      int w;

      check("rsp_valid", o_rspValid, rsp_pend ? onehot(g) : '0);
      if (rsp_pend) begin
         check("rsp_data", o_rspData, rsp_d);
         check("rsp_resp", o_rspResp, rsp_r);
         $display("txn %0d req=%0d %s addr=%h data=%h resp=%0d",
                  ntxn, g, wr ? "WR" : "RD", e_addr, wr ? e_data : rsp_d, rsp_r);
         ntxn++;
         busy = 0;
         rsp_pend = 0;
      end

      e_ar = busy && !wr && !ar_done;
      e_r  = busy && !wr && ar_done && !r_done;
      e_aw = busy && wr && !aw_done;
      e_w  = busy && wr && !w_done;
      e_b  = busy && wr && aw_done && w_done && !b_done;
      check("axi_ctl", {o_arValid, o_rReady, o_awValid, o_wValid, o_bReady},
                       {e_ar, e_r, e_aw, e_w, e_b});
      check("prot", {o_arProt, o_awProt}, 6'b0);
      if (e_ar) check("ar_addr", o_arAddr, e_addr);
      if (e_aw) check("aw_addr", o_awAddr, e_addr);
      if (e_w) begin
         check("w_data", o_wData, e_data);
         check("w_strb", o_wStrb, e_strb);
      end
      if (e_ar && i_arReady) ar_done = 1;
      if (e_aw && i_awReady) aw_done = 1;
      if (e_w && i_wReady)   w_done  = 1;
      if (e_r && i_rValid) begin
         r_done = 1; rsp_pend = 1; rsp_d = i_rData; rsp_r = i_rResp;
      end
      if (e_b && i_bValid) begin
         b_done = 1; rsp_pend = 1; rsp_d = '0; rsp_r = i_bResp;
      end

      exp_rdy = '0;
      w = -1;
      if (!busy && i_reqValid != '0) begin
         w = rr_pick(mptr, i_reqValid);
         exp_rdy = onehot(w);
      end
      if (post_chk) begin
         check("post_rst_grant", o_reqReady, onehot(0));
         post_chk = 0;
      end
      check("req_ready", o_reqReady, exp_rdy);
      if (w >= 0) begin
         busy = 1; g = w; wr = rq_w[w];
         e_addr = rq_a[w]; e_data = rq_d[w]; e_strb = rq_s[w];
         ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
         mptr = (w + 1) % N;
         hold[w] = 0;
      end
   endtask

   initial begin
      ntxn = 0; force_all = 0; post_chk = 0; mid_rst_done = 0;
      model_reset();
      drive_idle_inputs();
      rst = 1;
      i_reqValid = '1;
      #2;
      check("reset_outputs", any_output(), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      i_reqValid = '0;
      rst = 0;
      #2;
      check("post_reset_outputs", any_output(), 1'b0);

      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < ncyc[p]; c++) begin
            @(posedge clk);
            #1;
            drive_cycle(req_pct[p], rdy_pct[p]);
            #3;
            sample_cycle();
            // abort a read that is waiting on its data beat
            if (p == 2 && !mid_rst_done && busy && !wr && ar_done && !r_done) begin
               mid_rst_done = 1;
               drive_idle_inputs();
               rst = 1;
               #1;
               check("mid_reset_outputs", any_output(), 1'b0);
               @(posedge clk);
               #1;
               check("mid_reset_no_rsp", o_rspValid, '0);
               rst = 0;
               model_reset();
               force_all = 1;
               post_chk = 1;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
